rglib_rotate_clk_mon: RTL and testbench

Synthesizable clock monitor: the receive-side counterpart of the rotate clock generator. It samples a monitored clock `mon_in` in the `clk` domain and measures its period and high time in `clk` cycles. It flags out-of-window periods and detects a stopped clock. It sits beside the rotate datapath as a health checker and gives the bench a DUT-side observer for generated clocks.

---
 rtl/rglib_rotate_clk_mon.sv | 129 ++++++++++++
 tb/tb_rglib_rotate_clk_mon.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rglib_rotate_clk_mon.sv
// Clock monitor: measures period and high time of mon_in in clk cycles, flags
// out-of-window periods and detects a stopped clock. Optional input synchronizer: RGLIB_ROTATE_CLK_MON_SYNC_EN.
module rglib_rotate_clk_mon #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_in,
    input  logic [CNT_W-1:0] min_period,
    input  logic [CNT_W-1:0] max_period,
    input  logic [CNT_W-1:0] timeout,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             too_fast,
    output logic             too_slow,
    output logic             stopped
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, STOPPED} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (SYNC_STAGES < 2) begin : g_sync_stages_check
        $error("SYNC_STAGES must be at least 2");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [CNT_W-1:0] period_n, high_time_n;
    logic             period_vld_n, too_fast_n, too_slow_n;
    logic             s, s_q, rise, fall;

`ifdef RGLIB_ROTATE_CLK_MON_SYNC_EN
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], mon_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];
`else
    assign s = mon_in;
`endif

    assign rise    = s & ~s_q;
    assign fall    = ~s & s_q;
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
    assign stopped = (state == STOPPED);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        period_n     = period;
        high_time_n  = high_time;
        period_vld_n = 1'b0;
        // A set in the same cycle as clr overrides the clear below.
        too_fast_n   = too_fast & ~clr;
        too_slow_n   = too_slow & ~clr;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (rise) begin
                        cnt_n   = CNT_ONE;
                        state_n = MEASURE;
                    end
                end
                MEASURE: begin
                    cnt_n = cnt_inc;
                    if (rise) begin
                        period_n     = cnt;
                        period_vld_n = 1'b1;
                        cnt_n        = CNT_ONE;
                        if (cnt < min_period) too_fast_n = 1'b1;
                        if (cnt > max_period) too_slow_n = 1'b1;
                    end else if (fall) begin
                        high_time_n = cnt;
                    end else if (cnt >= timeout) begin
                        state_n = STOPPED;
                    end
                end
                STOPPED: begin
                    if (rise) begin
                        cnt_n   = CNT_ONE;
                        state_n = MEASURE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            high_time  <= '0;
            period_vld <= 1'b0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
            s_q        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            period     <= period_n;
            high_time  <= high_time_n;
            period_vld <= period_vld_n;
            too_fast   <= too_fast_n;
            too_slow   <= too_slow_n;
            s_q        <= s;
        end
    end

endmodule

// File: tb/tb_rglib_rotate_clk_mon.sv
// Self-checking bench for rglib_rotate_clk_mon: waveforms are built from (high, low)
// segments and expected results come straight from those segment lengths.
module tb_rglib_rotate_clk_mon;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
`ifdef RGLIB_ROTATE_CLK_MON_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    logic             clk, rst, en, mon_in, clr;
    logic [CNT_W-1:0] min_period, max_period, timeout;
    logic [CNT_W-1:0] period, high_time;
    logic             period_vld, too_fast, too_slow, stopped;

    rglib_rotate_clk_mon #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .en(en), .mon_in(mon_in),
        .min_period(min_period), .max_period(max_period), .timeout(timeout),
        .clr(clr), .period(period), .high_time(high_time), .period_vld(period_vld),
        .too_fast(too_fast), .too_slow(too_slow), .stopped(stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit wav[$];
    int exp_p[2048];
    int exp_h[2048];
    bit exp_v[2048];
    bit exp_fast, exp_slow;
    int seg_h[16];
    int seg_l[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic mark(input int pos, input int k, input int minp, input int maxp);
        int p;
        p = seg_h[k] + seg_l[k];
        exp_v[pos] = 1'b1;
        exp_p[pos] = p;
        exp_h[pos] = seg_h[k];
        if (p < minp) exp_fast = 1'b1;
        if (p > maxp) exp_slow = 1'b1;
    endtask

    // Waveform: lead zeros, nseg segments, then a closing rising edge held high.
    task automatic build(input int nseg, input int lead, input int minp, input int maxp);
        wav.delete();
        for (int i = 0; i < 2048; i++) exp_v[i] = 1'b0;
        repeat (lead) wav.push_back(1'b0);
        for (int k = 0; k < nseg; k++) begin
            if (k > 0) mark(wav.size(), k - 1, minp, maxp);
            repeat (seg_h[k]) wav.push_back(1'b1);
            repeat (seg_l[k]) wav.push_back(1'b0);
        end
        mark(wav.size(), nseg - 1, minp, maxp);
        repeat (LAT + 1) wav.push_back(1'b1);
    endtask

    task automatic play();
        int j;
        for (int i = 0; i < wav.size(); i++) begin
            mon_in = wav[i];
            tick();
            j = i - LAT;
            if (j >= 0) begin
                chk("period_vld", period_vld, exp_v[j]);
                if (exp_v[j]) begin
                    chk("period", period, exp_p[j]);
                    chk("high_time", high_time, exp_h[j]);
                end
                chk("stopped_run", stopped, 0);
            end
        end
    endtask

    task automatic start(input int minp, input int maxp, input int tmo);
        en = 1'b0;
        clr = 1'b1;
        mon_in = 1'b0;
        min_period = minp[CNT_W-1:0];
        max_period = maxp[CNT_W-1:0];
        timeout = tmo[CNT_W-1:0];
        repeat (LAT + 3) tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        exp_fast = 1'b0;
        exp_slow = 1'b0;
    endtask

    task automatic flags();
        chk("too_fast", too_fast, exp_fast);
        chk("too_slow", too_slow, exp_slow);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high_time"}, high_time, 0);
        chk({tag, "_vld"}, period_vld, 0);
        chk({tag, "_too_fast"}, too_fast, 0);
        chk({tag, "_too_slow"}, too_slow, 0);
        chk({tag, "_stopped"}, stopped, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mon_in = 1'b0; clr = 1'b0;
        min_period = 8; max_period = 12; timeout = 1000;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;

        // Nominal clock: period 10, high 4, inside the window.
        start(8, 12, 1000);
        for (int k = 0; k < 5; k++) begin seg_h[k] = 4; seg_l[k] = 6; end
        build(5, 0, 8, 12);
        play();
        flags();

        // Fast clock, then clear, then clear coincident with a new set.
        start(8, 12, 1000);
        for (int k = 0; k < 3; k++) begin seg_h[k] = 3; seg_l[k] = 3; end
        build(3, 0, 8, 12);
        play();
        flags();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("too_fast_cleared", too_fast, 0);
        mon_in = 1'b0;
        repeat (2) tick();
        mon_in = 1'b1;
        repeat (LAT) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_set_vld", period_vld, 1);
        chk("clr_set_period", period, 4 + LAT);
        chk("clr_set_too_fast", too_fast, 1);

        // Slow clock.
        start(8, 12, 1000);
        for (int k = 0; k < 3; k++) begin seg_h[k] = 8; seg_l[k] = 12; end
        build(3, 0, 8, 12);
        play();
        flags();

        // Stop the clock with timeout 30, then restart it.
        start(8, 12, 30);
        for (int k = 0; k < 3; k++) begin seg_h[k] = 4; seg_l[k] = 6; end
        build(3, 0, 8, 12);
        play();
        for (int k = 1; k <= 40; k++) begin
            mon_in = 1'b0;
            tick();
            chk("stopped", stopped, (k >= 30) ? 1 : 0);
            chk("stop_no_vld", period_vld, 0);
        end
        seg_h[0] = 4; seg_l[0] = 6;
        build(1, 0, 8, 12);
        play();
        flags();

        // Reset in the middle of a period.
        start(20, 30, 1000);
        for (int k = 0; k < 3; k++) begin seg_h[k] = 4; seg_l[k] = 6; end
        build(3, 0, 20, 30);
        play();
        flags();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_zero("mid_reset");
        rst = 1'b0;
        exp_fast = 1'b0;
        exp_slow = 1'b0;
        for (int k = 0; k < 2; k++) begin seg_h[k] = 4; seg_l[k] = 6; end
        build(2, 3, 20, 30);
        play();
        flags();

        // Randomized segments and windows (window may be inverted).
        for (int t = 0; t < 6; t++) begin
            int minp, maxp, nseg;
            minp = $urandom_range(30, 2);
            maxp = $urandom_range(30, 2);
            nseg = $urandom_range(12, 2);
            start(minp, maxp, 1000);
            for (int k = 0; k < nseg; k++) begin
                seg_h[k] = $urandom_range(15, 1);
                seg_l[k] = $urandom_range(15, 1);
            end
            build(nseg, $urandom_range(5, 0), minp, maxp);
            play();
            flags();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
